// File: rtl/riscv_i32_pkg.sv
// Shared encodings and types for the RV32 trap sequencer slice.
package riscv_i32_pkg;

  localparam logic [2:0] FA_NONE       = 3'd0;
  localparam logic [2:0] FA_SEQUENTIAL = 3'd1;
  localparam logic [2:0] FA_REDIRECT   = 3'd2;

  localparam logic [2:0] MODE_USER    = 3'd0;
  localparam logic [2:0] MODE_MACHINE = 3'd3;

  localparam logic [3:0] CAUSE_ILLEGAL_INSN = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_U      = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

  typedef enum logic [1:0] {StReset, StRedirect, StRunning, StHalted} seq_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [2:0]  mpp;
  } trap_csr_t;

  // Vector base ignores the mode bits of mtvec.
  function automatic logic [31:0] vector_base(input logic [31:0] mtvec);
    return mtvec & ~32'h3;
  endfunction

endpackage

// File: rtl/riscv_i32_irq_priority.sv
// Lowest-index-wins interrupt encoder.
module riscv_i32_irq_priority
  import riscv_i32_pkg::*;
#(
  parameter int unsigned num_irqs = 16
) (
  input  logic [num_irqs-1:0] pending,
  output logic                any,
  output logic [3:0]          number
);

  assign any = |pending;

  // Scan downward so the lowest set index is the last assignment.
  always_comb begin
    number = 4'd0;
    for (int i = int'(num_irqs) - 1; i >= 0; i--) begin
      if (pending[i]) number = 4'(i);
    end
  end

endmodule

// File: rtl/riscv_i32_trap_sequencer.sv
// Registers execute-stage control-flow events into fetch redirects, privilege
// mode, trap CSR updates, interrupt handshake and debug halt.
module riscv_i32_trap_sequencer
  import riscv_i32_pkg::*;
#(
  parameter logic [31:0] reset_vector = 32'h0,
  parameter int unsigned num_irqs     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                control_flow__trap__valid,
  input  logic                control_flow__trap__ret,
  input  logic                control_flow__trap__ebreak_to_dbg,
  input  logic [3:0]          control_flow__trap__cause,
  input  logic [2:0]          control_flow__trap__to_mode,
  input  logic [31:0]         control_flow__trap__pc,
  input  logic [31:0]         control_flow__trap__value,
  input  logic                control_flow__branch_taken,
  input  logic                control_flow__jalr,
  input  logic                control_flow__async_cancel,
  input  logic [31:0]         control_flow__next_pc,
  input  logic [31:0]         csr_mtvec,
  input  logic                csr_mie,
  input  logic [num_irqs-1:0] irq_pending,
  input  logic                dbg_halt_req,
  input  logic                dbg_resume_req,
  output logic                pipeline_control__valid,
  output logic [2:0]          pipeline_control__fetch_action,
  output logic [31:0]         pipeline_control__decode_pc,
  output logic [2:0]          pipeline_control__mode,
  output logic                pipeline_control__halt,
  output logic                pipeline_control__interrupt_req,
  output logic [3:0]          pipeline_control__interrupt_number,
  output logic [2:0]          pipeline_control__interrupt_to_mode,
  output logic                trap_csr__write,
  output logic [31:0]         trap_csr__mepc,
  output logic [31:0]         trap_csr__mcause,
  output logic [31:0]         trap_csr__mtval,
  output logic [2:0]          trap_csr__mpp
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  mode_q, mode_d;
  logic        irq_req_q, irq_req_d;
  logic [3:0]  irq_num_q, irq_num_d;
  trap_csr_t   csr_q, csr_d;
  logic        irq_any;
  logic [3:0]  irq_num;

  riscv_i32_irq_priority #(
    .num_irqs(num_irqs)
  ) u_irq_priority (
    .pending(irq_pending),
    .any    (irq_any),
    .number (irq_num)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StReset;
      pc_q      <= reset_vector;
      mode_q    <= MODE_MACHINE;
      irq_req_q <= 1'b0;
      irq_num_q <= 4'd0;
      csr_q     <= '{write: 1'b0, mepc: 32'h0, mcause: 32'h0, mtval: 32'h0, mpp: MODE_MACHINE};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mode_q    <= mode_d;
      irq_req_q <= irq_req_d;
      irq_num_q <= irq_num_d;
      csr_q     <= csr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mode_d        = mode_q;
    irq_req_d     = irq_req_q;
    irq_num_d     = irq_num_q;
    csr_d         = csr_q;
    csr_d.write   = 1'b0;

    unique case (state_q)
      StReset: begin
        state_d = StRedirect;
        pc_d    = reset_vector;
      end
      StRedirect: state_d = StRunning;
      StRunning: begin
        if (control_flow__async_cancel && control_flow__trap__valid) begin
          csr_d.write  = 1'b1;
          csr_d.mcause = {1'b1, 27'b0, control_flow__trap__cause};
          csr_d.mepc   = control_flow__trap__pc;
          csr_d.mtval  = 32'h0;
          csr_d.mpp    = mode_q;
          mode_d       = control_flow__trap__to_mode;
          pc_d         = vector_base(csr_mtvec);
          state_d      = StRedirect;
        end else if (control_flow__trap__valid && control_flow__trap__ebreak_to_dbg) begin
          csr_d.mepc = control_flow__trap__pc;
          state_d    = StHalted;
        end else if (control_flow__trap__valid) begin
          csr_d.write  = 1'b1;
          csr_d.mcause = {28'b0, control_flow__trap__cause};
          csr_d.mepc   = control_flow__trap__pc;
          csr_d.mtval  = control_flow__trap__value;
          csr_d.mpp    = mode_q;
          mode_d       = control_flow__trap__to_mode;
          pc_d         = vector_base(csr_mtvec);
          state_d      = StRedirect;
        end else if (control_flow__trap__ret) begin
          csr_d.write = 1'b1;
          csr_d.mpp   = MODE_USER;
          mode_d      = csr_q.mpp;
          pc_d        = csr_q.mepc;
          state_d     = StRedirect;
        end else if (control_flow__branch_taken) begin
          pc_d    = control_flow__next_pc & ~{31'b0, control_flow__jalr};
          state_d = StRedirect;
        end else if (dbg_halt_req) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (dbg_resume_req && !dbg_halt_req) begin
          pc_d    = csr_q.mepc;
          state_d = StRedirect;
        end
      end
      default: state_d = StReset;
    endcase

    // A held request is retired by the cancel, or withdrawn if interrupts get disabled first.
    if (irq_req_q) begin
      if (!csr_mie || (state_q == StRunning && control_flow__async_cancel)) irq_req_d = 1'b0;
    end else if (state_q == StRunning && state_d == StRunning && csr_mie && irq_any) begin
      irq_req_d = 1'b1;
      irq_num_d = irq_num;
    end
    if (state_d == StHalted) irq_req_d = 1'b0;
  end

  always_comb begin
    pipeline_control__valid        = 1'b0;
    pipeline_control__fetch_action = FA_NONE;
    unique case (state_q)
      StRedirect: begin
        pipeline_control__valid        = 1'b1;
        pipeline_control__fetch_action = FA_REDIRECT;
      end
      StRunning: begin
        pipeline_control__valid        = 1'b1;
        pipeline_control__fetch_action = FA_SEQUENTIAL;
      end
      default: ;
    endcase
  end

  assign pipeline_control__decode_pc         = pc_q;
  assign pipeline_control__mode              = mode_q;
  assign pipeline_control__halt              = (state_q == StHalted);
  assign pipeline_control__interrupt_req     = irq_req_q;
  assign pipeline_control__interrupt_number  = irq_num_q;
  assign pipeline_control__interrupt_to_mode = MODE_MACHINE;
  assign trap_csr__write                     = csr_q.write;
  assign trap_csr__mepc                      = csr_q.mepc;
  assign trap_csr__mcause                    = csr_q.mcause;
  assign trap_csr__mtval                     = csr_q.mtval;
  assign trap_csr__mpp                       = csr_q.mpp;

endmodule

// File: tb/tb_riscv_i32_trap_sequencer.sv
// Scoreboard bench: each cycle's expected outputs are queued with the stimulus
// and compared one edge later.
module tb_riscv_i32_trap_sequencer;
  import riscv_i32_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_valid, t_ret, t_ebreak;
  logic [3:0]  t_cause;
  logic [2:0]  t_to_mode;
  logic [31:0] t_pc, t_value;
  logic        br_taken, jalr, async_cancel;
  logic [31:0] next_pc, mtvec;
  logic        mie;
  logic [15:0] irq_pending;
  logic        halt_req, resume_req;

  logic        o_valid, o_halt, o_irq, o_wr;
  logic [2:0]  o_fa, o_mode, o_irq_mode, o_mpp;
  logic [31:0] o_pc, o_mepc, o_mcause, o_mtval;
  logic [3:0]  o_irq_num;

  typedef struct {
    logic        valid;
    logic [2:0]  fa;
    logic [31:0] pc;
    logic [2:0]  mode;
    logic        halt;
    logic        irq;
    logic [3:0]  irq_num;
    logic        wr;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [2:0]  mpp;
  } exp_t;

  exp_t e;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  riscv_i32_trap_sequencer #(
    .reset_vector(RV),
    .num_irqs    (16)
  ) dut (
    .clk                                 (clk),
    .reset                               (reset),
    .control_flow__trap__valid           (t_valid),
    .control_flow__trap__ret             (t_ret),
    .control_flow__trap__ebreak_to_dbg   (t_ebreak),
    .control_flow__trap__cause           (t_cause),
    .control_flow__trap__to_mode         (t_to_mode),
    .control_flow__trap__pc              (t_pc),
    .control_flow__trap__value           (t_value),
    .control_flow__branch_taken          (br_taken),
    .control_flow__jalr                  (jalr),
    .control_flow__async_cancel          (async_cancel),
    .control_flow__next_pc               (next_pc),
    .csr_mtvec                           (mtvec),
    .csr_mie                             (mie),
    .irq_pending                         (irq_pending),
    .dbg_halt_req                        (halt_req),
    .dbg_resume_req                      (resume_req),
    .pipeline_control__valid             (o_valid),
    .pipeline_control__fetch_action      (o_fa),
    .pipeline_control__decode_pc         (o_pc),
    .pipeline_control__mode              (o_mode),
    .pipeline_control__halt              (o_halt),
    .pipeline_control__interrupt_req     (o_irq),
    .pipeline_control__interrupt_number  (o_irq_num),
    .pipeline_control__interrupt_to_mode (o_irq_mode),
    .trap_csr__write                     (o_wr),
    .trap_csr__mepc                      (o_mepc),
    .trap_csr__mcause                    (o_mcause),
    .trap_csr__mtval                     (o_mtval),
    .trap_csr__mpp                       (o_mpp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL step%0d %s: got %h expected %h", step_no, tag, got, exp);
    end
  endtask

  // Queue the expectation, advance one edge, then compare against the oldest entry.
  task automatic step();
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check_eq("valid", {31'b0, o_valid}, {31'b0, x.valid});
      check_eq("fetch_action", {29'b0, o_fa}, {29'b0, x.fa});
      check_eq("decode_pc", o_pc, x.pc);
      check_eq("mode", {29'b0, o_mode}, {29'b0, x.mode});
      check_eq("halt", {31'b0, o_halt}, {31'b0, x.halt});
      check_eq("irq_req", {31'b0, o_irq}, {31'b0, x.irq});
      check_eq("irq_num", {28'b0, o_irq_num}, {28'b0, x.irq_num});
      check_eq("irq_to_mode", {29'b0, o_irq_mode}, {29'b0, MODE_MACHINE});
      check_eq("csr_write", {31'b0, o_wr}, {31'b0, x.wr});
      check_eq("mepc", o_mepc, x.mepc);
      check_eq("mcause", o_mcause, x.mcause);
      check_eq("mtval", o_mtval, x.mtval);
      check_eq("mpp", {29'b0, o_mpp}, {29'b0, x.mpp});
    end
  endtask

  task automatic idle_inputs();
    t_valid = 0; t_ret = 0; t_ebreak = 0; t_cause = 0; t_to_mode = MODE_MACHINE;
    t_pc = 0; t_value = 0; br_taken = 0; jalr = 0; async_cancel = 0; next_pc = 0;
    halt_req = 0; resume_req = 0;
  endtask

  task automatic exp_reset();
    e = '{valid: 1'b0, fa: FA_NONE, pc: RV, mode: MODE_MACHINE, halt: 1'b0, irq: 1'b0,
          irq_num: 4'd0, wr: 1'b0, mepc: 32'h0, mcause: 32'h0, mtval: 32'h0, mpp: MODE_MACHINE};
  endtask

  task automatic exp_run();
    e.valid = 1; e.fa = FA_SEQUENTIAL; e.halt = 0; e.wr = 0;
  endtask

  task automatic exp_redirect(input logic [31:0] pc);
    e.valid = 1; e.fa = FA_REDIRECT; e.halt = 0; e.pc = pc; e.wr = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1; mtvec = 32'h103; mie = 0; irq_pending = 0;
    exp_reset(); step();
    exp_reset(); step();

    // Reset release: one redirect to the reset vector, then sequential.
    reset = 0;
    exp_redirect(RV); step();
    exp_run(); step();

    // jalr clears bit 0; plain branch keeps it.
    br_taken = 1; jalr = 1; next_pc = 32'h1001;
    exp_redirect(32'h1000); step();
    idle_inputs(); exp_run(); step();
    br_taken = 1; jalr = 0; next_pc = 32'h2001;
    exp_redirect(32'h2001); step();
    idle_inputs(); exp_run(); step();

    // Synchronous trap from machine mode.
    t_valid = 1; t_cause = CAUSE_ECALL_M; t_pc = 32'h200; t_value = 32'h55;
    exp_redirect(32'h100); e.wr = 1; e.mepc = 32'h200; e.mcause = 32'hb; e.mtval = 32'h55;
    e.mpp = MODE_MACHINE; e.mode = MODE_MACHINE; step();
    idle_inputs(); exp_run(); step();

    // First xRET restores machine and leaves mpp=user; second drops to user.
    t_ret = 1;
    exp_redirect(32'h200); e.wr = 1; e.mode = MODE_MACHINE; e.mpp = MODE_USER; step();
    idle_inputs(); exp_run(); step();
    t_ret = 1;
    exp_redirect(32'h200); e.wr = 1; e.mode = MODE_USER; e.mpp = MODE_USER; step();
    idle_inputs(); exp_run(); step();

    // Trap from user wins over a simultaneous branch.
    t_valid = 1; t_cause = CAUSE_ILLEGAL_INSN; t_pc = 32'h300; t_value = 32'hdead;
    br_taken = 1; next_pc = 32'h9998;
    exp_redirect(32'h100); e.wr = 1; e.mepc = 32'h300; e.mcause = 32'h2; e.mtval = 32'hdead;
    e.mpp = MODE_USER; e.mode = MODE_MACHINE; step();
    idle_inputs(); exp_run(); step();

    // Interrupt request: lowest index, held while pending changes.
    mie = 1; irq_pending = 16'h0028;
    exp_run(); e.irq = 1; e.irq_num = 4'd3; step();
    irq_pending = 16'h0001;
    exp_run(); step();
    irq_pending = 16'h0000;
    exp_run(); step();

    // Acceptance via async cancel + trap.
    async_cancel = 1; t_valid = 1; t_cause = CAUSE_BREAKPOINT; t_pc = 32'h400; t_value = 32'h77;
    exp_redirect(32'h100); e.wr = 1; e.irq = 0; e.mepc = 32'h400; e.mcause = 32'h8000_0003;
    e.mtval = 32'h0; e.mpp = MODE_MACHINE; e.mode = MODE_MACHINE; step();
    idle_inputs(); exp_run(); step();

    // Request withdrawn when mie drops.
    irq_pending = 16'h0010;
    exp_run(); e.irq = 1; e.irq_num = 4'd4; step();
    mie = 0;
    exp_run(); e.irq = 0; step();
    irq_pending = 16'h0000;
    exp_run(); step();

    // ebreak into debug: mepc captured, no CSR write strobe.
    t_valid = 1; t_ebreak = 1; t_cause = CAUSE_BREAKPOINT; t_pc = 32'h40; t_value = 32'h123;
    e.valid = 0; e.fa = FA_NONE; e.halt = 1; e.wr = 0; e.mepc = 32'h40; step();
    idle_inputs(); halt_req = 1; resume_req = 1;
    step();
    halt_req = 0; resume_req = 1;
    exp_redirect(32'h40); step();
    idle_inputs(); exp_run(); step();

    // Debug halt request; a pending interrupt must not be raised across it.
    halt_req = 1; mie = 1; irq_pending = 16'h0001;
    e.valid = 0; e.fa = FA_NONE; e.halt = 1; step();
    halt_req = 0;
    step();
    resume_req = 1; irq_pending = 16'h0000;
    exp_redirect(32'h40); step();
    idle_inputs(); exp_run(); step();

    // Reset while a request is held.
    irq_pending = 16'h8000;
    exp_run(); e.irq = 1; e.irq_num = 4'd15; step();
    reset = 1;
    exp_reset(); step();
    reset = 0; irq_pending = 16'h0000;
    exp_reset(); exp_redirect(RV); step();
    exp_run(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
